// File: rtl/memory_access_if.sv
// Shared RV32I types (riscv_pkg) and the MEM-stage data-memory bus interface.
// req/we/addr/be/wdata go toward memory; gnt/rvalid/rdata come back.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [5:0] {
    UNKNOWN, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
  } operation_e;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            valid;
  } rd_port_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT_GNT,
    MEM_WAIT_RVALID
  } mem_state_e;
endpackage

// Handshake: once req=1, we/addr/be/wdata stay stable until the cycle with
// gnt=1, which is the transfer. A granted load returns exactly one rvalid in a
// later cycle. At most one transaction is outstanding.
interface memory_access_if;
  logic                       dmem_req;
  logic                       dmem_we;
  logic [riscv_pkg::XLEN-1:0] dmem_addr;
  logic [3:0]                 dmem_be;
  logic [riscv_pkg::XLEN-1:0] dmem_wdata;
  logic                       dmem_gnt;
  logic                       dmem_rvalid;
  logic [riscv_pkg::XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/memory_access.sv
// MEM stage of the RV32I pipeline: load/store on a req/gnt/rvalid port, MEM/WB register.
// Optional feature macro MEM_TIMEOUT_EN: abort a wait after TIMEOUT_CYCLES and pulse err_o.
module memory_access
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       pcM_i,
  input  logic [XLEN-1:0]       instrM_i,
  input  operation_e            operationM_i,
  input  rd_port_t              rdM_port_i,
  input  logic                  memM_wrt_ena_i,
  input  logic [XLEN-1:0]       memM_addr_i,
  input  logic [XLEN-1:0]       memM_wdata_i,
  memory_access_if.master       dmem,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic                  err_o,
  output logic [XLEN-1:0]       pcW_o,
  output logic [XLEN-1:0]       instrW_o,
  output operation_e            operationW_o,
  output rd_port_t              rdW_port_o,
  output mem_state_e            state_dbg_o
);

  mem_state_e      state_q;
  logic            is_load, is_store, misaligned, mem_go;
  logic [1:0]      size_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;

  operation_e      op_q;
  logic [XLEN-1:0] addr_q, wdata_q, pc_q, instr_q;
  logic [3:0]      be_q;
  logic [4:0]      rd_q;
  logic            we_q, drop_q;
  logic [XLEN-1:0] lane, load_data;
  logic            wait_exit, timeout_hit;

  assign state_dbg_o = state_q;

  // Decode of the instruction currently presented by execute.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_c   = 2'd0;
    case (operationM_i)
      LB, LBU: begin is_load  = rdM_port_i.valid; size_c = 2'd0; end
      LH, LHU: begin is_load  = rdM_port_i.valid; size_c = 2'd1; end
      LW:      begin is_load  = rdM_port_i.valid; size_c = 2'd2; end
      SB:      begin is_store = memM_wrt_ena_i;   size_c = 2'd0; end
      SH:      begin is_store = memM_wrt_ena_i;   size_c = 2'd1; end
      SW:      begin is_store = memM_wrt_ena_i;   size_c = 2'd2; end
      default: ;
    endcase
    misaligned = ((size_c == 2'd1) && memM_addr_i[0]) ||
                 ((size_c == 2'd2) && (memM_addr_i[1:0] != 2'b00));
    mem_go     = (is_load || is_store) && !flush_i && !misaligned;
    case (size_c)
      2'd0:    begin be_c = 4'b0001 << memM_addr_i[1:0]; wdata_c = {4{memM_wdata_i[7:0]}}; end
      2'd1:    begin be_c = 4'b0011 << memM_addr_i[1:0]; wdata_c = {2{memM_wdata_i[15:0]}}; end
      default: begin be_c = 4'b1111;                     wdata_c = memM_wdata_i; end
    endcase
  end

  // Load lane extraction from the latched byte offset.
  always_comb begin
    lane = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
    case (op_q)
      LB:      load_data = {{24{lane[7]}}, lane[7:0]};
      LBU:     load_data = {24'h0, lane[7:0]};
      LH:      load_data = {{16{lane[15]}}, lane[15:0]};
      LHU:     load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  assign wait_exit = ((state_q == MEM_WAIT_GNT) && dmem.dmem_gnt) ||
                     ((state_q == MEM_WAIT_RVALID) && dmem.dmem_rvalid);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_hit = (state_q != MEM_IDLE) && !wait_exit &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if ((state_q == MEM_IDLE) || wait_exit || timeout_hit) cnt_q <= '0;
      else                                                   cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  // Bus drive: live values from execute in IDLE, latched copies while waiting for gnt.
  always_comb begin
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_be    = 4'b0000;
    dmem.dmem_wdata = '0;
    if (!rst_i) begin
      if ((state_q == MEM_IDLE) && mem_go) begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = is_store;
        dmem.dmem_addr  = {memM_addr_i[XLEN-1:2], 2'b00};
        dmem.dmem_be    = be_c;
        dmem.dmem_wdata = wdata_c;
      end else if (state_q == MEM_WAIT_GNT) begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = we_q;
        dmem.dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
        dmem.dmem_be    = be_q;
        dmem.dmem_wdata = wdata_q;
      end
    end
  end

  // Stall drops in the completion (or abort) cycle so upstream advances with the result.
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        MEM_IDLE:        stall_o = mem_go && !(is_store && dmem.dmem_gnt);
        MEM_WAIT_GNT:    stall_o = !(we_q && dmem.dmem_gnt) && !timeout_hit;
        MEM_WAIT_RVALID: stall_o = !dmem.dmem_rvalid && !timeout_hit;
        default:         stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= MEM_IDLE;
      op_q         <= UNKNOWN;
      addr_q       <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      instr_q      <= '0;
      be_q         <= 4'b0000;
      rd_q         <= '0;
      we_q         <= 1'b0;
      drop_q       <= 1'b0;
      misalign_o   <= 1'b0;
      pcW_o        <= '0;
      instrW_o     <= '0;
      operationW_o <= UNKNOWN;
      rdW_port_o   <= '0;
    end else begin
      misalign_o   <= 1'b0;
      pcW_o        <= '0;
      instrW_o     <= '0;
      operationW_o <= UNKNOWN;
      rdW_port_o   <= '0;
      case (state_q)
        MEM_IDLE: begin
          if (flush_i) begin
            // squashed: bubble
          end else if ((is_load || is_store) && misaligned) begin
            misalign_o   <= 1'b1;
            pcW_o        <= pcM_i;
            instrW_o     <= instrM_i;
            operationW_o <= operationM_i;
          end else if (mem_go) begin
            op_q    <= operationM_i;
            addr_q  <= memM_addr_i;
            wdata_q <= wdata_c;
            be_q    <= be_c;
            we_q    <= is_store;
            rd_q    <= rdM_port_i.addr;
            pc_q    <= pcM_i;
            instr_q <= instrM_i;
            drop_q  <= 1'b0;
            if (is_store && dmem.dmem_gnt) begin
              pcW_o        <= pcM_i;
              instrW_o     <= instrM_i;
              operationW_o <= operationM_i;
            end else if (dmem.dmem_gnt) begin
              state_q <= MEM_WAIT_RVALID;
            end else begin
              state_q <= MEM_WAIT_GNT;
            end
          end else begin
            rdW_port_o   <= rdM_port_i;
            pcW_o        <= pcM_i;
            instrW_o     <= instrM_i;
            operationW_o <= operationM_i;
          end
        end
        MEM_WAIT_GNT: begin
          if (flush_i) drop_q <= 1'b1;
          if (dmem.dmem_gnt) begin
            if (we_q) begin
              state_q      <= MEM_IDLE;
              drop_q       <= 1'b0;
              pcW_o        <= pc_q;
              instrW_o     <= instr_q;
              operationW_o <= op_q;
            end else begin
              state_q <= MEM_WAIT_RVALID;
            end
          end else if (timeout_hit) begin
            state_q <= MEM_IDLE;
            drop_q  <= 1'b0;
          end
        end
        MEM_WAIT_RVALID: begin
          if (flush_i) drop_q <= 1'b1;
          if (dmem.dmem_rvalid) begin
            state_q      <= MEM_IDLE;
            drop_q       <= 1'b0;
            rdW_port_o   <= '{addr: rd_q, data: load_data, valid: !drop_q && !flush_i};
            pcW_o        <= pc_q;
            instrW_o     <= instr_q;
            operationW_o <= op_q;
          end else if (timeout_hit) begin
            state_q <= MEM_IDLE;
            drop_q  <= 1'b0;
          end
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: single-cycle vector table plus multi-cycle load/store sequences.
module tb_memory_access;
  import riscv_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [31:0]     pcM, instrM, addrM, wdataM;
  operation_e      opM;
  rd_port_t        rdM;
  logic            wrt;
  logic            stall, misalign, err;
  logic [31:0]     pcW, instrW;
  operation_e      opW;
  rd_port_t        rdW;
  mem_state_e      st;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  memory_access_if dmem_bus ();

  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .pcM_i(pcM), .instrM_i(instrM), .operationM_i(opM), .rdM_port_i(rdM),
    .memM_wrt_ena_i(wrt), .memM_addr_i(addrM), .memM_wdata_i(wdataM),
    .dmem(dmem_bus),
    .stall_o(stall), .misalign_o(misalign), .err_o(err),
    .pcW_o(pcW), .instrW_o(instrW), .operationW_o(opW), .rdW_port_o(rdW),
    .state_dbg_o(st)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    operation_e  op;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wrt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        flush;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_mis;
    operation_e  e_op;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    flush = 1'b0; opM = UNKNOWN; rdM = '0; wrt = 1'b0;
    addrM = '0; wdataM = '0; pcM = '0; instrM = '0;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input string nm, input operation_e op, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [3:0] e_be, input int gnt_wait,
                          input int rv_wait, input logic [31:0] rdata, input logic [31:0] exp);
    exp_q.push_back(exp);
    opM = op; rdM = '{addr: rd, data: 32'h0, valid: 1'b1}; wrt = 1'b0;
    addrM = addr; pcM = 32'hA000 | addr; instrM = 32'h0000_0003;
    for (int c = 0; c <= gnt_wait; c++) begin
      dmem_bus.dmem_gnt = (c == gnt_wait);
      @(negedge clk);
      check({nm, "_req"}, 32'(dmem_bus.dmem_req), 32'd1);
      check({nm, "_addr"}, dmem_bus.dmem_addr, {addr[31:2], 2'b00});
      check({nm, "_be"}, 32'(dmem_bus.dmem_be), 32'(e_be));
      check({nm, "_we"}, 32'(dmem_bus.dmem_we), 32'd0);
      check({nm, "_stall_g"}, 32'(stall), 32'd1);
      next_cycle();
      check({nm, "_bubble"}, 32'(rdW.valid), 32'd0);
    end
    dmem_bus.dmem_gnt = 1'b0;
    for (int c = 0; c <= rv_wait; c++) begin
      dmem_bus.dmem_rvalid = (c == rv_wait);
      dmem_bus.dmem_rdata  = (c == rv_wait) ? rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      check({nm, "_req_rv"}, 32'(dmem_bus.dmem_req), 32'd0);
      check({nm, "_stall_rv"}, 32'(stall), (c == rv_wait) ? 32'd0 : 32'd1);
      next_cycle();
    end
    drive_idle();
    check({nm, "_valid"}, 32'(rdW.valid), 32'd1);
    check({nm, "_rd"}, 32'(rdW.addr), 32'(rd));
    check({nm, "_data"}, rdW.data, exp_q.pop_front());
    check({nm, "_opW"}, 32'(opW), 32'(op));
    check({nm, "_pcW"}, pcW, 32'hA000 | addr);
  endtask

  initial begin
    vecs[0]  = '{"add_rd5",   ADD, 5'd5, 32'h11, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 5'd5, 32'h11, 1'b0, ADD};
    vecs[1]  = '{"sb_lane3",  SB, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1003, 32'hAB, 1'b1, 1'b0,
                 1'b1, 1'b1, 32'h1000, 4'b1000, 32'hABABABAB, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, SB};
    vecs[2]  = '{"sh_upper",  SH, 5'd0, 32'h0, 1'b0, 1'b1, 32'h2002, 32'h1234BEEF, 1'b1, 1'b0,
                 1'b1, 1'b1, 32'h2000, 4'b1100, 32'hBEEFBEEF, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, SH};
    vecs[3]  = '{"sw_word",   SW, 5'd0, 32'h0, 1'b0, 1'b1, 32'h3000, 32'hDEADBEEF, 1'b1, 1'b0,
                 1'b1, 1'b1, 32'h3000, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, SW};
    vecs[4]  = '{"sb_lane1",  SB, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1001, 32'h55, 1'b1, 1'b0,
                 1'b1, 1'b1, 32'h1000, 4'b0010, 32'h55555555, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, SB};
    vecs[5]  = '{"lw_misal",  LW, 5'd7, 32'h0, 1'b1, 1'b0, 32'h2001, 32'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, LW};
    vecs[6]  = '{"sh_misal",  SH, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1001, 32'h77, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, SH};
    vecs[7]  = '{"sb_no_wrt", SB, 5'd0, 32'h0, 1'b0, 1'b0, 32'h10, 32'h1, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, SB};
    vecs[8]  = '{"lb_no_val", LB, 5'd3, 32'h0, 1'b0, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, LB};
    vecs[9]  = '{"add_flush", ADD, 5'd5, 32'h22, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, UNKNOWN};
    vecs[10] = '{"sw_flush",  SW, 5'd0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h9, 1'b1, 1'b1,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, UNKNOWN};
    vecs[11] = '{"xor_rd31",  XOR, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, XOR};
    vecs[12] = '{"lhu_misal", LHU, 5'd2, 32'h0, 1'b1, 1'b0, 32'h0103, 32'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, LHU};
    vecs[13] = '{"sw_misal",  SW, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1002, 32'h3, 1'b1, 1'b0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, SW};

    // Clock/reset
    drive_idle();
    rst = 1'b1;
    repeat (2) next_cycle();
    check("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rst_rdW", 32'(rdW), 32'd0);
    check("rst_rdW_data", rdW.data, 32'd0);
    check("rst_pcW", pcW, 32'd0);
    check("rst_opW", 32'(opW), 32'(UNKNOWN));
    check("rst_misal", 32'(misalign), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(st), 32'(MEM_IDLE));
    rst = 1'b0;
    next_cycle();

    // Single-cycle vectors
    for (int i = 0; i < NV; i++) begin
      opM = vecs[i].op; rdM = '{addr: vecs[i].rd, data: vecs[i].rd_data, valid: vecs[i].rd_valid};
      wrt = vecs[i].wrt; addrM = vecs[i].addr; wdataM = vecs[i].wdata; flush = vecs[i].flush;
      dmem_bus.dmem_gnt = vecs[i].gnt; pcM = 32'h100 + 32'(i * 4); instrM = 32'h1000 + 32'(i);
      @(negedge clk);
      check({vecs[i].name, "_req"}, 32'(dmem_bus.dmem_req), 32'(vecs[i].e_req));
      check({vecs[i].name, "_stall"}, 32'(stall), 32'(vecs[i].e_stall));
      if (vecs[i].e_req) begin
        check({vecs[i].name, "_we"}, 32'(dmem_bus.dmem_we), 32'(vecs[i].e_we));
        check({vecs[i].name, "_addr"}, dmem_bus.dmem_addr, vecs[i].e_addr);
        check({vecs[i].name, "_be"}, 32'(dmem_bus.dmem_be), 32'(vecs[i].e_be));
        check({vecs[i].name, "_wdata"}, dmem_bus.dmem_wdata, vecs[i].e_wdata);
      end
      next_cycle();
      check({vecs[i].name, "_valid"}, 32'(rdW.valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check({vecs[i].name, "_rd"}, 32'(rdW.addr), 32'(vecs[i].e_rd));
        check({vecs[i].name, "_data"}, rdW.data, vecs[i].e_data);
      end
      check({vecs[i].name, "_misal"}, 32'(misalign), 32'(vecs[i].e_mis));
      check({vecs[i].name, "_opW"}, 32'(opW), 32'(vecs[i].e_op));
      if (vecs[i].e_op != UNKNOWN) check({vecs[i].name, "_pcW"}, pcW, 32'h100 + 32'(i * 4));
      check({vecs[i].name, "_state"}, 32'(st), 32'(MEM_IDLE));
    end
    drive_idle();
    next_cycle();

    // Loads through the full req/gnt/rvalid path
    load_seq("lb_sext",  LB,  5'd9,  32'h2002, 4'b0100, 0, 1, 32'h0080_0000, 32'hFFFFFF80);
    load_seq("lhu_zext", LHU, 5'd10, 32'h2002, 4'b1100, 0, 0, 32'h8001_0000, 32'h00008001);
    load_seq("lbu_gw2",  LBU, 5'd11, 32'h2003, 4'b1000, 2, 0, 32'hF000_0000, 32'h000000F0);
    load_seq("lw_gw1",   LW,  5'd12, 32'h3008, 4'b1111, 1, 2, 32'hCAFE_F00D, 32'hCAFEF00D);
    load_seq("lh_lane0", LH,  5'd13, 32'h0000, 4'b0011, 0, 0, 32'h0000_8001, 32'hFFFF8001);

    // LW with 3-cycle gnt delay, changing inputs, then flush in WAIT_RVALID
    opM = LW; rdM = '{addr: 5'd6, data: 32'h0, valid: 1'b1}; addrM = 32'h3004; pcM = 32'h500;
    for (int c = 0; c < 4; c++) begin
      dmem_bus.dmem_gnt = (c == 3);
      if (c == 1) begin addrM = 32'h5550; opM = LB; end
      @(negedge clk);
      check("lwd_req", 32'(dmem_bus.dmem_req), 32'd1);
      check("lwd_addr", dmem_bus.dmem_addr, 32'h3004);
      check("lwd_be", 32'(dmem_bus.dmem_be), 32'hF);
      check("lwd_stall", 32'(stall), 32'd1);
      next_cycle();
    end
    dmem_bus.dmem_gnt = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("lwd_req_rv", 32'(dmem_bus.dmem_req), 32'd0);
    check("lwd_stall_rv", 32'(stall), 32'd1);
    next_cycle();
    flush = 1'b0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("lwd_stall_done", 32'(stall), 32'd0);
    next_cycle();
    drive_idle();
    check("lwd_flush_valid", 32'(rdW.valid), 32'd0);
    check("lwd_state", 32'(st), 32'(MEM_IDLE));

    // gnt and rvalid together from WAIT_GNT: the rvalid is not the load's data
    exp_q.push_back(32'hFFFF8000);
    opM = LH; rdM = '{addr: 5'd8, data: 32'h0, valid: 1'b1}; addrM = 32'h0006; pcM = 32'h600;
    @(negedge clk);
    check("gr_req", 32'(dmem_bus.dmem_req), 32'd1);
    check("gr_be", 32'(dmem_bus.dmem_be), 32'hC);
    next_cycle();
    dmem_bus.dmem_gnt = 1'b1; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("gr_stall_both", 32'(stall), 32'd1);
    next_cycle();
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;
    @(negedge clk);
    check("gr_stall_wait", 32'(stall), 32'd1);
    next_cycle();
    check("gr_not_done", 32'(rdW.valid), 32'd0);
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h8000_1234;
    next_cycle();
    drive_idle();
    check("gr_valid", 32'(rdW.valid), 32'd1);
    check("gr_rd", 32'(rdW.addr), 32'd8);
    check("gr_data", rdW.data, exp_q.pop_front());

    // Store with delayed gnt: latched wdata held while upstream inputs change
    opM = SH; wrt = 1'b1; addrM = 32'h4002; wdataM = 32'h0000_CAFE; pcM = 32'h700;
    @(negedge clk);
    check("shd_stall0", 32'(stall), 32'd1);
    check("shd_wdata0", dmem_bus.dmem_wdata, 32'hCAFECAFE);
    next_cycle();
    check("shd_bubble", 32'(rdW.valid), 32'd0);
    wdataM = 32'h0000_1111; dmem_bus.dmem_gnt = 1'b1;
    @(negedge clk);
    check("shd_req", 32'(dmem_bus.dmem_req), 32'd1);
    check("shd_we", 32'(dmem_bus.dmem_we), 32'd1);
    check("shd_be", 32'(dmem_bus.dmem_be), 32'hC);
    check("shd_wdata1", dmem_bus.dmem_wdata, 32'hCAFECAFE);
    check("shd_stall1", 32'(stall), 32'd0);
    next_cycle();
    drive_idle();
    check("shd_opW", 32'(opW), 32'(SH));
    check("shd_pcW", pcW, 32'h700);
    check("shd_state", 32'(st), 32'(MEM_IDLE));

    // Reset in the middle of a transaction
    opM = LW; rdM = '{addr: 5'd4, data: 32'h0, valid: 1'b1}; addrM = 32'h8;
    next_cycle();
    check("rmid_state", 32'(st), 32'(MEM_WAIT_GNT));
    rst = 1'b1;
    #1;
    check("rmid_req", 32'(dmem_bus.dmem_req), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive_idle();
    check("rmid_idle", 32'(st), 32'(MEM_IDLE));
    check("rmid_opW", 32'(opW), 32'(UNKNOWN));
    @(negedge clk);
    check("rmid_req_after", 32'(dmem_bus.dmem_req), 32'd0);
    next_cycle();

    // gnt never arrives
    opM = LW; rdM = '{addr: 5'd1, data: 32'h0, valid: 1'b1}; addrM = 32'h100;
`ifdef MEM_TIMEOUT_EN
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("to_req", 32'(dmem_bus.dmem_req), 32'd1);
      check("to_stall", 32'(stall), (c == 4) ? 32'd0 : 32'd1);
      next_cycle();
      if (c < 4) check("to_err_early", 32'(err), 32'd0);
    end
    drive_idle();
    check("to_err", 32'(err), 32'd1);
    check("to_state", 32'(st), 32'(MEM_IDLE));
    check("to_valid", 32'(rdW.valid), 32'd0);
    @(negedge clk);
    check("to_req_off", 32'(dmem_bus.dmem_req), 32'd0);
    next_cycle();
    check("to_err_pulse", 32'(err), 32'd0);
`else
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      check("wait_err", 32'(err), 32'd0);
    end
    @(negedge clk);
    check("wait_req", 32'(dmem_bus.dmem_req), 32'd1);
    check("wait_stall", 32'(stall), 32'd1);
    dmem_bus.dmem_gnt = 1'b1;
    next_cycle();
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h0BAD_F00D;
    next_cycle();
    drive_idle();
    check("wait_data", rdW.data, 32'h0BADF00D);
    check("wait_state", 32'(st), 32'(MEM_IDLE));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
